// File: rtl/aes_key_expand_iter.sv
// Iterative AES-128 key schedule: round keys 0..10 leave one per rk_valid/rk_ready handshake.
// Round 0 is valid one cycle after start; with rk_ready held high, 11 keys stream on consecutive cycles; stalls hold the outputs.

module aes_sbox_word #(
    parameter int IMPL = 0
) (
    input  logic [31:0] din,
    output logic [31:0] dout
);
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the byte index is the bit-inverted input.
    function automatic logic [7:0] sbox_lut(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as b^254 (maps 0 to 0), then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox_alg(input logic [7:0] b);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(b, b);
        x3   = gf_mul(x2, b);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_byte
        if (IMPL == 0 || IMPL == 4) begin : g_lut
            assign dout[8*i +: 8] = sbox_lut(din[8*i +: 8]);
        end else begin : g_alg
            assign dout[8*i +: 8] = sbox_alg(din[8*i +: 8]);
        end
    end
endmodule

module aes_key_expand_iter #(
    parameter int SBOX_IMPL = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_key,
    output logic [3:0]   rk_round,
    output logic         rk_last,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  n0, n1, n2, n3;
    logic         hs;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    assign {w0, w1, w2, w3} = key_q;
    assign rot_w = {w3[23:0], w3[31:24]};

    aes_sbox_word #(.IMPL(SBOX_IMPL)) u_sbox (
        .din  (rot_w),
        .dout (sub_w)
    );

    assign t_w = sub_w ^ {rcon_q, 24'h0};
    assign n0  = w0 ^ t_w;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;

    assign rk_valid = (state_q == EMIT);
    assign busy     = (state_q == EMIT);
    assign rk_key   = key_q;
    assign rk_round = round_q;
    assign rk_last  = rk_valid && (round_q == 4'd10);
    assign done     = done_q;
    assign hs       = rk_valid && rk_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key;
                    round_d = 4'd0;
                    rcon_d  = 8'h01;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (hs) begin
                    if (round_q == 4'd10) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = {n0, n1, n2, n3};
                        round_d = round_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_aes_key_expand_iter.sv
// Directed bench for aes_key_expand_iter: FIPS-197 and zero-key schedules, stalls, ignored start,
// mid-schedule reset, and agreement across all S-box implementations.
module tb_aes_key_expand_iter;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         rk_ready = 1'b0;
    logic [127:0] key = '0;

    logic         rk_valid [5];
    logic [127:0] rk_key   [5];
    logic [3:0]   rk_round [5];
    logic         rk_last  [5];
    logic         busy     [5];
    logic         done     [5];

    int checks = 0;
    int errors = 0;

    logic [127:0] fips_exp [11];
    logic [127:0] fips_key;
    logic [127:0] zero_r1;
    logic [127:0] zero_r10;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        aes_key_expand_iter #(.SBOX_IMPL(g)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start),
            .key      (key),
            .rk_valid (rk_valid[g]),
            .rk_ready (rk_ready),
            .rk_key   (rk_key[g]),
            .rk_round (rk_round[g]),
            .rk_last  (rk_last[g]),
            .busy     (busy[g]),
            .done     (done[g])
        );
    end

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rk_valid[0] !== 1'b0 || rk_key[0] !== 128'h0 || rk_round[0] !== 4'd0 ||
            rk_last[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b key=%h round=%0d last=%b busy=%b done=%b want all zero",
                     rk_valid[0], rk_key[0], rk_round[0], rk_last[0], busy[0], done[0]);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rk_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got valid=%b busy=%b want 0 0", rk_valid[0], busy[0]);
        end
    endtask

    task automatic test_fips();
        int dones;
        dones = 0;
        rk_ready = 1'b1;
        start = 1'b1;
        key = fips_key;
        @(negedge clk);
        start = 1'b0;
        key = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
        for (int r = 0; r <= 10; r++) begin
            checks++;
            if (rk_valid[0] !== 1'b1 || busy[0] !== 1'b1 || rk_round[0] !== r[3:0] ||
                rk_key[0] !== fips_exp[r] || rk_last[0] !== (r == 10)) begin
                errors++;
                $display("FAIL fips_round%0d: got valid=%b busy=%b round=%0d last=%b key=%h want 1 1 %0d %b %h",
                         r, rk_valid[0], busy[0], rk_round[0], rk_last[0], rk_key[0], r, (r == 10), fips_exp[r]);
            end
            if (done[0] === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (done[0] !== 1'b1 || rk_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL fips_done: got done=%b valid=%b busy=%b want 1 0 0", done[0], rk_valid[0], busy[0]);
        end
        if (done[0] === 1'b1) dones++;
        @(negedge clk);
        if (done[0] === 1'b1) dones++;
        @(negedge clk);
        if (done[0] === 1'b1) dones++;
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL fips_done_pulses: got %0d want 1", dones);
        end
    endtask

    task automatic test_zero_key();
        rk_ready = 1'b1;
        start = 1'b1;
        key = 128'h0;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r <= 10; r++) begin
            checks++;
            if (rk_valid[0] !== 1'b1 || rk_round[0] !== r[3:0]) begin
                errors++;
                $display("FAIL zero_seq%0d: got valid=%b round=%0d want 1 %0d", r, rk_valid[0], rk_round[0], r);
            end
            if (r == 0 || r == 1 || r == 10) begin
                checks++;
                if (rk_key[0] !== (r == 0 ? 128'h0 : (r == 1 ? zero_r1 : zero_r10))) begin
                    errors++;
                    $display("FAIL zero_key_round%0d: got %h want %h", r, rk_key[0],
                             (r == 0 ? 128'h0 : (r == 1 ? zero_r1 : zero_r10)));
                end
            end
            @(negedge clk);
        end
        checks++;
        if (done[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: got %b want 1", done[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_stalls();
        int   r;
        int   hold;
        int   cyc;
        logic h3;
        logic h7;
        logic acc;
        r = 0; hold = 0; cyc = 0; h3 = 1'b0; h7 = 1'b0;
        rk_ready = 1'b0;
        start = 1'b1;
        key = fips_key;
        @(negedge clk);
        start = 1'b0;
        while (r <= 10 && cyc < 600) begin
            checks++;
            if (rk_valid[0] !== 1'b1 || rk_round[0] !== r[3:0] || rk_key[0] !== fips_exp[r]) begin
                errors++;
                $display("FAIL stall_cyc%0d: got valid=%b round=%0d key=%h want 1 %0d %h",
                         cyc, rk_valid[0], rk_round[0], rk_key[0], r, fips_exp[r]);
            end
            if ((r == 3 && !h3) || (r == 7 && !h7)) begin
                hold = 20;
                if (r == 3) h3 = 1'b1;
                else h7 = 1'b1;
            end
            if (hold > 0) begin
                rk_ready = 1'b0;
                hold--;
            end else begin
                rk_ready = 1'($urandom_range(0, 1));
            end
            acc = rk_ready;
            @(negedge clk);
            if (acc) r++;
            cyc++;
        end
        checks++;
        if (r != 11) begin
            errors++;
            $display("FAIL stall_timeout: reached round %0d want 11 accepted", r);
        end
        checks++;
        if (done[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: got %b want 1", done[0]);
        end
        rk_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        rk_ready = 1'b1;
        start = 1'b1;
        key = fips_key;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r <= 10; r++) begin
            checks++;
            if (rk_round[0] !== r[3:0] || rk_key[0] !== fips_exp[r]) begin
                errors++;
                $display("FAIL ign_round%0d: got round=%0d key=%h want %0d %h",
                         r, rk_round[0], rk_key[0], r, fips_exp[r]);
            end
            if (r == 5 || r == 10) begin
                start = 1'b1;
                key = 128'h0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (done[0] !== 1'b1 || rk_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL ign_at_last: got done=%b valid=%b want 1 0", done[0], rk_valid[0]);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (rk_valid[0] !== 1'b1 || rk_round[0] !== 4'd0 || rk_key[0] !== 128'h0 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL reload_round0: got valid=%b round=%0d key=%h done=%b want 1 0 0 0",
                     rk_valid[0], rk_round[0], rk_key[0], done[0]);
        end
        @(negedge clk);
        checks++;
        if (rk_round[0] !== 4'd1 || rk_key[0] !== zero_r1) begin
            errors++;
            $display("FAIL reload_round1: got round=%0d key=%h want 1 %h", rk_round[0], rk_key[0], zero_r1);
        end
        for (int i = 0; i < 9; i++) @(negedge clk);
        checks++;
        if (rk_round[0] !== 4'd10 || rk_key[0] !== zero_r10 || rk_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL reload_round10: got round=%0d last=%b key=%h want 10 1 %h",
                     rk_round[0], rk_last[0], rk_key[0], zero_r10);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        rk_ready = 1'b1;
        start = 1'b1;
        key = fips_key;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 6; r++) @(negedge clk);
        checks++;
        if (rk_round[0] !== 4'd6 || rk_key[0] !== fips_exp[6]) begin
            errors++;
            $display("FAIL rstmid_round6: got round=%0d key=%h want 6 %h", rk_round[0], rk_key[0], fips_exp[6]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (rk_valid[0] !== 1'b0 || rk_key[0] !== 128'h0 || rk_round[0] !== 4'd0 ||
            rk_last[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got valid=%b key=%h round=%0d busy=%b done=%b want all zero",
                     rk_valid[0], rk_key[0], rk_round[0], busy[0], done[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        key = fips_key;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r <= 10; r++) begin
            checks++;
            if (rk_valid[0] !== 1'b1 || rk_round[0] !== r[3:0] || rk_key[0] !== fips_exp[r]) begin
                errors++;
                $display("FAIL rstmid_round%0d: got valid=%b round=%0d key=%h want 1 %0d %h",
                         r, rk_valid[0], rk_round[0], rk_key[0], r, fips_exp[r]);
            end
            @(negedge clk);
        end
        checks++;
        if (done[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_done: got %b want 1", done[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_sbox_impls();
        rk_ready = 1'b1;
        start = 1'b1;
        key = fips_key;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r <= 10; r++) begin
            for (int g = 1; g < 5; g++) begin
                checks++;
                if (rk_valid[g] !== 1'b1 || rk_round[g] !== r[3:0] || rk_key[g] !== fips_exp[r]) begin
                    errors++;
                    $display("FAIL impl%0d_round%0d: got valid=%b round=%0d key=%h want 1 %0d %h",
                             g, r, rk_valid[g], rk_round[g], rk_key[g], r, fips_exp[r]);
                end
            end
            @(negedge clk);
        end
        for (int g = 1; g < 5; g++) begin
            checks++;
            if (done[g] !== 1'b1) begin
                errors++;
                $display("FAIL impl%0d_done: got %b want 1", g, done[g]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        fips_key     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_exp[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_exp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_exp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_exp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_exp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_exp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_exp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_exp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_exp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_exp[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_exp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zero_r1      = 128'h62636363626363636263636362636363;
        zero_r10     = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        test_reset();
        test_fips();
        test_zero_key();
        test_stalls();
        test_start_ignored();
        test_reset_mid();
        test_sbox_impls();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
